// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one command (address, beat count, direction) into a
// single AXI4 INCR burst. Write beats stream in on wr_*, read beats stream out
// on rd_*; a one-cycle done pulse reports the worst response and any error.
//
// Handshake semantics (all streams and AXI channels): a transfer happens on a
// rising edge where valid && ready are both 1. A valid, once raised, is held
// with its payload stable until the transfer. The W and R paths are
// combinational pass-throughs gated by state, so the upstream/downstream
// stream inherits the AXI channel's handshake directly.
module axi_burst_master #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
  parameter int AXI_ID_WIDTH     = 16,
  parameter int AXI_ID           = 0,
  parameter int MAX_BURST_LEN    = 256,
  parameter int LEN_W            = $clog2(MAX_BURST_LEN) + 1
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  // command
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]            cmd_len,
  // write-data stream
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  // read-data stream
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic                        rd_last,
  // completion
  output logic                        done_valid,
  output logic [1:0]                  done_resp,
  output logic                        done_err,
  // FSM state for observation
  output logic [2:0]                  fsm_state,
  // AW
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  // W
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_STROBE_WIDTH-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  // B
  input  logic [1:0]                  m_axi_bresp,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // AR
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  // R
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int                      SIZE   = $clog2(AXI_STROBE_WIDTH);
  localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              err_q;
  logic [1:0]        resp_q;
  logic [31:0]       span_end;
  logic              cmd_bad;
  logic              accept;
  logic              last_beat;
  logic              w_hs;
  logic              r_hs;
  logic              b_hs;

  // Byte offset one past the burst inside its 4 KB page; equal to 4096 is legal.
  assign span_end  = 32'(cmd_addr[11:0]) + 32'(cmd_len) * 32'(AXI_STROBE_WIDTH);
  assign cmd_bad   = (cmd_len == '0)
                  || (cmd_len > LEN_W'(MAX_BURST_LEN))
                  || (|cmd_addr[SIZE-1:0])
                  || (span_end > 32'd4096);
  assign accept    = cmd_valid && (state_q == IDLE) && !s_axi_areset;
  assign last_beat = (cnt_q == (len_q - LEN_W'(1)));
  assign w_hs      = (state_q == WR_DATA) && wr_valid && m_axi_wready;
  assign r_hs      = (state_q == RD_DATA) && m_axi_rvalid && rd_ready;
  assign b_hs      = (state_q == WR_RESP) && m_axi_bvalid;

  assign fsm_state     = state_q;
  assign m_axi_awid    = ID_VAL;
  assign m_axi_arid    = ID_VAL;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = '1;
  assign rd_data       = m_axi_rdata;

  // State register.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state and state-gated handshake outputs.
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done_valid    = 1'b0;
    done_resp     = 2'b00;
    done_err      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !s_axi_areset;
        if (accept) state_d = cmd_bad ? DONE : (cmd_write ? WR_ADDR : RD_ADDR);
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = last_beat;
        if (w_hs && last_beat) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = DONE;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        // The beat count, not the slave's rlast, defines the end of the burst.
        rd_last      = last_beat;
        if (r_hs && last_beat) state_d = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        done_resp  = resp_q;
        done_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, beat counter, address registers and sticky status.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_q       <= 2'b00;
      m_axi_awaddr <= '0;
      m_axi_awlen  <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
    end else begin
      if (accept) begin
        len_q  <= cmd_len;
        cnt_q  <= '0;
        err_q  <= cmd_bad;
        resp_q <= 2'b00;
        if (!cmd_bad && cmd_write) begin
          m_axi_awaddr <= cmd_addr;
          m_axi_awlen  <= 8'(cmd_len - LEN_W'(1));
        end
        if (!cmd_bad && !cmd_write) begin
          m_axi_araddr <= cmd_addr;
          m_axi_arlen  <= 8'(cmd_len - LEN_W'(1));
        end
      end
      if (w_hs) cnt_q <= last_beat ? '0 : cnt_q + LEN_W'(1);
      if (b_hs) begin
        if (m_axi_bresp > resp_q) resp_q <= m_axi_bresp;
        if (m_axi_bid != ID_VAL)  err_q  <= 1'b1;
      end
      if (r_hs) begin
        cnt_q <= last_beat ? '0 : cnt_q + LEN_W'(1);
        if (m_axi_rresp > resp_q)          resp_q <= m_axi_rresp;
        if (m_axi_rid != ID_VAL)           err_q  <= 1'b1;
        if (m_axi_rlast != last_beat)      err_q  <= 1'b1;
      end
      if (state_q == DONE) begin
        err_q  <= 1'b0;
        resp_q <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays the AXI slave and the
// stream endpoints cycle by cycle and checks every observable output.
module tb_axi_burst_master;

  logic          clk = 1'b0;
  logic          s_axi_areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [31:0]   cmd_addr;
  logic [8:0]    cmd_len;
  logic [127:0]  wr_data;
  logic          wr_valid, wr_ready;
  logic [127:0]  rd_data;
  logic          rd_valid, rd_ready, rd_last;
  logic          done_valid, done_err;
  logic [1:0]    done_resp;
  logic [2:0]    fsm_state;
  logic [31:0]   awaddr, araddr;
  logic [15:0]   awid, arid, bid, rid;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, arvalid, arready;
  logic [127:0]  wdata, rdata;
  logic [15:0]   wstrb;
  logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int vectors = 0;
  int errors  = 0;

  // Clock
  always #5 clk = ~clk;

  axi_burst_master dut (
    .s_axi_aclk(clk), .s_axi_areset(s_axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .fsm_state(fsm_state),
    .m_axi_awaddr(awaddr), .m_axi_awid(awid), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bid(bid), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arid(arid), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rid(rid), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] a, input int b);
    return {64'h0, a, 32'(b)};
  endfunction

  // Presents one command for one cycle; returns just after the handshake edge.
  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [8:0] l);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    #1;
    chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic reject_cmd(input logic w, input logic [31:0] a, input logic [8:0] l);
    issue_cmd(w, a, l);
    #1;
    chk("rej_awvalid", 128'(awvalid), 128'(0));
    chk("rej_arvalid", 128'(arvalid), 128'(0));
    chk("rej_done_valid", 128'(done_valid), 128'(1));
    chk("rej_done_err", 128'(done_err), 128'(1));
    chk("rej_done_resp", 128'(done_resp), 128'(0));
    tick();
    chk("rej_cmd_ready_back", 128'(cmd_ready), 128'(1));
    chk("rej_done_clear", 128'(done_valid), 128'(0));
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [8:0] l, input int delay,
                             input logic [1:0] bresp_v, input logic [15:0] bid_v,
                             input logic exp_err);
    issue_cmd(1'b1, a, l);
    for (int d = 0; d < delay; d++) begin
      #1;
      chk("aw_hold_valid", 128'(awvalid), 128'(1));
      chk("aw_hold_addr", 128'(awaddr), 128'(a));
      chk("aw_hold_len", 128'(awlen), 128'(8'(l - 9'd1)));
      chk("aw_no_ar", 128'(arvalid), 128'(0));
      chk("aw_cmd_ready_low", 128'(cmd_ready), 128'(0));
      tick();
    end
    awready = 1'b1;
    #1;
    chk("awvalid", 128'(awvalid), 128'(1));
    chk("awaddr", 128'(awaddr), 128'(a));
    chk("awlen", 128'(awlen), 128'(8'(l - 9'd1)));
    chk("awsize", 128'(awsize), 128'(4));
    chk("awburst", 128'(awburst), 128'(1));
    chk("awid", 128'(awid), 128'(0));
    tick();
    awready = 1'b0;
    for (int beat = 1; beat <= int'(l); beat++) begin
      wr_valid = 1'b1; wr_data = beat_data(a, beat); wready = 1'b1;
      #1;
      chk("wvalid", 128'(wvalid), 128'(1));
      chk("wdata", wdata, beat_data(a, beat));
      chk("wlast", 128'(wlast), 128'(beat == int'(l)));
      chk("wr_ready", 128'(wr_ready), 128'(1));
      chk("wstrb", 128'(wstrb), 128'(16'hFFFF));
      chk("w_cmd_ready_low", 128'(cmd_ready), 128'(0));
      tick();
    end
    wr_valid = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = bresp_v; bid = bid_v;
    #1;
    chk("bready", 128'(bready), 128'(1));
    chk("wvalid_after_last", 128'(wvalid), 128'(0));
    tick();
    bvalid = 1'b0;
    #1;
    chk("wr_done_valid", 128'(done_valid), 128'(1));
    chk("wr_done_err", 128'(done_err), 128'(exp_err));
    chk("wr_done_resp", 128'(done_resp), 128'(bresp_v));
    chk("wr_done_cmd_ready", 128'(cmd_ready), 128'(0));
    tick();
    chk("wr_cmd_ready_back", 128'(cmd_ready), 128'(1));
    chk("wr_done_clear", 128'(done_valid), 128'(0));
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [8:0] l, input logic toggle,
                            input int rlast_beat, input logic [1:0] last_resp,
                            input logic exp_err);
    int beat;
    int cyc;
    issue_cmd(1'b0, a, l);
    #1;
    chk("arvalid", 128'(arvalid), 128'(1));
    chk("araddr", 128'(araddr), 128'(a));
    chk("arlen", 128'(arlen), 128'(8'(l - 9'd1)));
    chk("arsize", 128'(arsize), 128'(4));
    chk("arburst", 128'(arburst), 128'(1));
    chk("ar_no_aw", 128'(awvalid), 128'(0));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    beat = 1;
    cyc  = 0;
    while (beat <= int'(l) && cyc < 64) begin
      rvalid   = 1'b1;
      rdata    = beat_data(a, beat);
      rresp    = (beat == int'(l)) ? last_resp : 2'b00;
      rid      = 16'h0;
      rlast    = (rlast_beat == 0) ? (beat == int'(l)) : (beat == rlast_beat);
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("rd_valid", 128'(rd_valid), 128'(1));
      chk("rd_data", rd_data, beat_data(a, beat));
      chk("rready", 128'(rready), 128'(rd_ready));
      if (rd_ready) begin
        chk("rd_last", 128'(rd_last), 128'(beat == int'(l)));
        beat++;
      end
      tick();
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    chk("rd_all_beats", 128'(beat), 128'(int'(l) + 1));
    #1;
    chk("rd_done_valid", 128'(done_valid), 128'(1));
    chk("rd_done_err", 128'(done_err), 128'(exp_err));
    chk("rd_done_resp", 128'(done_resp), 128'(last_resp));
    chk("rd_done_cmd_ready", 128'(cmd_ready), 128'(0));
    tick();
    chk("rd_cmd_ready_back", 128'(cmd_ready), 128'(1));
    chk("rd_done_clear", 128'(done_valid), 128'(0));
  endtask

  initial begin
    s_axi_areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bresp = 2'b00; bid = '0; bvalid = 1'b0;
    rdata = '0; rresp = 2'b00; rid = '0; rlast = 1'b0; rvalid = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_awvalid", 128'(awvalid), 128'(0));
    chk("rst_arvalid", 128'(arvalid), 128'(0));
    chk("rst_wvalid", 128'(wvalid), 128'(0));
    chk("rst_wlast", 128'(wlast), 128'(0));
    chk("rst_bready", 128'(bready), 128'(0));
    chk("rst_rready", 128'(rready), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_last", 128'(rd_last), 128'(0));
    chk("rst_done_valid", 128'(done_valid), 128'(0));
    chk("rst_done_err", 128'(done_err), 128'(0));
    chk("rst_done_resp", 128'(done_resp), 128'(0));
    chk("rst_awaddr", 128'(awaddr), 128'(0));
    chk("rst_araddr", 128'(araddr), 128'(0));
    chk("rst_awlen", 128'(awlen), 128'(0));
    chk("rst_arlen", 128'(arlen), 128'(0));
    chk("rst_state", 128'(fsm_state), 128'(0));
    s_axi_areset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));

    // Plain 4-beat write
    write_burst(32'h0000_1000, 9'd4, 0, 2'b00, 16'h0, 1'b0);

    // 8-beat read, consumer toggling, SLVERR on the last beat
    read_burst(32'h0000_2000, 9'd8, 1'b1, 0, 2'b10, 1'b0);

    // Rejected commands: 4 KB crossing, zero length, misaligned, too long
    reject_cmd(1'b1, 32'h0000_0FF0, 9'd2);
    reject_cmd(1'b0, 32'h0000_3000, 9'd0);
    reject_cmd(1'b1, 32'h0000_1004, 9'd1);
    reject_cmd(1'b0, 32'h0000_0000, 9'd257);

    // Burst ending exactly on a 4 KB boundary is legal
    write_burst(32'h0000_0FE0, 9'd2, 0, 2'b00, 16'h0, 1'b0);

    // Early rlast on beat 2: all 4 beats still taken, error flagged
    read_burst(32'h0000_3000, 9'd4, 1'b0, 2, 2'b00, 1'b1);

    // Wrong BID and EXOKAY response
    write_burst(32'h0000_8000, 9'd2, 0, 2'b01, 16'h0001, 1'b1);

    // Reset in the middle of a 5-beat write
    issue_cmd(1'b1, 32'h0000_4000, 9'd5);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    for (int beat = 1; beat <= 2; beat++) begin
      wr_valid = 1'b1; wr_data = beat_data(32'h0000_4000, beat); wready = 1'b1;
      #1;
      chk("mid_wvalid", 128'(wvalid), 128'(1));
      tick();
    end
    s_axi_areset = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(0));
    tick();
    chk("mid_rst_wvalid", 128'(wvalid), 128'(0));
    chk("mid_rst_wr_ready", 128'(wr_ready), 128'(0));
    chk("mid_rst_done_valid", 128'(done_valid), 128'(0));
    chk("mid_rst_awaddr", 128'(awaddr), 128'(0));
    chk("mid_rst_state", 128'(fsm_state), 128'(0));
    s_axi_areset = 1'b0; wr_valid = 1'b0; wready = 1'b0;
    #1;
    chk("mid_rst_cmd_ready_back", 128'(cmd_ready), 128'(1));
    tick();
    chk("mid_rst_no_done", 128'(done_valid), 128'(0));
    write_burst(32'h0000_5000, 9'd1, 0, 2'b00, 16'h0, 1'b0);

    // Back-to-back: write with slow AWREADY, then read
    write_burst(32'h0000_6000, 9'd3, 5, 2'b00, 16'h0, 1'b0);
    read_burst(32'h0000_7000, 9'd2, 1'b0, 0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

- Synthesizable AXI4 master engine.
- Turns single commands (address, beat count, direction) into one INCR burst on a full AXI4 master port:
  - Write data is taken from an input stream.
  - Read data is delivered on an output stream.
- Generalises our single-beat simulation write/read sequences to parametrised width and burst length, with response and protocol checking.
- Sits between PL datapath logic and the memory-mapped interconnect.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 128, data width; power of two, 32..1024
- AXI_STROBE_WIDTH, AXI_DATA_WIDTH>>3, derived; not overridden
- AXI_ID_WIDTH, 16, ID width
- AXI_ID, 0, constant AWID/ARID value
- MAX_BURST_LEN, 256, max beats per command; 1..256
- LEN_W, $clog2(MAX_BURST_LEN)+1, derived command-length width

Ports (one clock; reset is synchronous and active-high):
- s_axi_aclk  in  1  clock; all logic on rising edge
- s_axi_areset  in  1  synchronous active-high reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; must be AXI_STROBE_WIDTH-aligned
- cmd_len  in  LEN_W  beat count, 1..MAX_BURST_LEN
- wr_data / wr_valid / wr_ready  in/in/out  AXI_DATA_WIDTH/1/1  write-data stream
- rd_data / rd_valid / rd_ready / rd_last  out/out/in/out  AXI_DATA_WIDTH/1/1/1  read-data stream
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  worst BRESP/RRESP seen during the command
- done_err  out  1  command rejected or protocol violation
- m_axi_aw*: awaddr, awid, awlen[7:0], awsize[2:0], awburst[1:0], awvalid (out); awready (in)
- m_axi_w*: wdata, wstrb, wlast, wvalid (out); wready (in)
- m_axi_b*: bresp[1:0], bid, bvalid (in); bready (out)
- m_axi_ar*: araddr, arid, arlen, arsize, arburst, arvalid (out); arready (in)
- m_axi_r*: rdata, rresp, rid, rlast, rvalid (in); rready (out)

## Operation
FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- **IDLE**
  - cmd_ready=1. On cmd_valid&&cmd_ready, latch the command.
  - Reject the command (go to DONE with done_err=1, no bus activity) when any of these holds:
    - cmd_len==0
    - cmd_len>MAX_BURST_LEN
    - address misaligned
    - the burst crosses a 4 KB boundary: (cmd_addr[11:0] + cmd_len*AXI_STROBE_WIDTH) > 4096
  - Otherwise go to WR_ADDR or RD_ADDR.
- **WR_ADDR**
  - awvalid=1, awlen=cmd_len-1, awsize=$clog2(AXI_STROBE_WIDTH), awburst=2'b01 (INCR).
  - Hold all AW fields stable until awready; then go to WR_DATA.
- **WR_DATA**
  - wvalid=wr_valid, wr_ready=wready, wdata=wr_data, wstrb all ones.
  - A beat counter increments per W handshake; wlast=1 exactly when counter==cmd_len-1.
  - After the last handshake go to WR_RESP.
- **WR_RESP**
  - bready=1. On bvalid, capture bresp. If bid!=AXI_ID, set done_err. Go to DONE.
- **RD_ADDR**: same rules as WR_ADDR on the AR channel; go to RD_DATA on arready.
- **RD_DATA**
  - rready=rd_ready, rd_valid=rvalid, rd_data=rdata.
  - rd_last=1 on the counter's last beat, independent of m_axi_rlast.
  - Error conditions (set done_err):
    - rlast=1 on a non-final beat: the burst still runs to cmd_len beats.
    - rlast=0 on the final beat: go to DONE anyway.
    - rid!=AXI_ID.
  - done_resp = numeric max of all rresp values in the burst.
- **DONE**: done_valid=1 for one cycle with done_resp/done_err; next state IDLE; sticky error/resp registers clear.
- Outside its state, every valid/ready output is 0. No outstanding transactions beyond one command.

## Timing
- Reset values:
  - cmd_ready=0 during reset, 1 the cycle after deassertion.
  - awvalid, arvalid, wvalid, wlast, bready, rready, rd_valid, rd_last, done_valid, done_err: all 0.
  - done_resp, awaddr, araddr, awlen, arlen: 0.
  - State = IDLE.
- AW/AR outputs are registered: awvalid/arvalid rise the cycle after the command handshake.
- W and R paths are combinational pass-through gated by state: zero added latency and no buffering.
- done_valid rises the cycle after the B handshake, or the cycle after the final R handshake; cmd_ready returns one cycle later.
- Rejected command: done_valid the cycle after the handshake.
- Reset asserted mid-burst: all outputs go to reset values at the next edge and the FSM returns to IDLE. No done_valid is issued; the in-flight bus transaction is abandoned and the interconnect is reset alongside.
- bvalid or rvalid arriving in a non-matching state is ignored (ready held 0).

## Test plan
- Write addr 0x1000, len 4, data 0x..01..0x..04, awready and wready tied 1, bresp=0 → awlen=3, awsize=4 (128-bit); wlast only on beat 4; done_valid with done_resp=0, done_err=0.
- Read addr 0x2000, len 8, rresp=0 on beats 1-7 and 2 on beat 8, rd_ready toggling 1/0 each cycle → 8 rd beats in order; rd_last on 8th; done_resp=2.
- Command addr 0x0FF0, len 2 (crosses 4 KB), plus len 0 → no awvalid/arvalid; done_valid with done_err=1 one cycle after each handshake.
- Read len 4 with slave asserting rlast on beat 2 → 4 beats still accepted; done_err=1.
- Reset pulsed during WR_DATA after 2 of 5 beats → next cycle wvalid=0 and done_valid=0; following a write of len 1, completes normally.
- Back-to-back write then read with awready delayed 5 cycles → awaddr/awlen stable throughout; read starts only after write done_valid; cmd_ready low during both.
